// File: rtl/wvb_seg_pkg.sv
// Shared types and header layout helpers for the segmented waveform-buffer write controller.
// Header is packed MSB-first as {ovfl, cont, src, ltc, stop_addr, start_addr}.
package wvb_seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      OVFL  = 2'd2
   } wvb_state_t;

   localparam int HDR_FLAG_W = 1;

   function automatic int hdr_w(input int adr_w, input int ltc_w, input int src_w);
      return 2*adr_w + ltc_w + src_w + 2*HDR_FLAG_W;
   endfunction

   function automatic int hdr_start_lsb();
      return 0;
   endfunction

   function automatic int hdr_stop_lsb(input int adr_w);
      return adr_w;
   endfunction

   function automatic int hdr_ltc_lsb(input int adr_w);
      return 2*adr_w;
   endfunction

   function automatic int hdr_src_lsb(input int adr_w, input int ltc_w);
      return 2*adr_w + ltc_w;
   endfunction

   function automatic int hdr_cont_lsb(input int adr_w, input int ltc_w, input int src_w);
      return 2*adr_w + ltc_w + src_w;
   endfunction

   function automatic int hdr_ovfl_lsb(input int adr_w, input int ltc_w, input int src_w);
      return 2*adr_w + ltc_w + src_w + HDR_FLAG_W;
   endfunction

endpackage

// File: rtl/wvb_seg_wr_ctrl.sv
// Waveform buffer write controller: writes triggered waveforms, splits them into
// length-capped segments and emits one header word per segment.
module wvb_seg_wr_ctrl
   import wvb_seg_pkg::*;
#(
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_LTC_WIDTH  = 48,
   parameter int P_PRE_WIDTH  = 5,
   parameter int P_POST_WIDTH = 8,
   parameter int P_LEN_WIDTH  = 12,
   parameter int P_SRC_WIDTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [P_LTC_WIDTH-1:0]  ltc,
   input  logic [P_PRE_WIDTH-1:0]  pre_config,
   input  logic [P_POST_WIDTH-1:0] post_config,
   input  logic [P_LEN_WIDTH-1:0]  max_len_config,
   input  logic [P_LEN_WIDTH-1:0]  fixed_len_config,
   input  logic                    trig_mode,
   input  logic                    trig,
   input  logic [P_SRC_WIDTH-1:0]  trig_src,
   input  logic                    arm,
   input  logic                    overflow_in,
   output logic                    armed,
   output logic [P_ADR_WIDTH-1:0]  wvb_wr_addr,
   output logic                    wvb_wren,
   output logic [hdr_w(P_ADR_WIDTH, P_LTC_WIDTH, P_SRC_WIDTH)-1:0] hdr_data,
   output logic                    hdr_wren,
   output logic                    eoe,
   output logic                    overflow_out
);

   localparam int LOAD_W = P_PRE_WIDTH + P_POST_WIDTH + 1;
   localparam int CNT_W  = (LOAD_W > P_LEN_WIDTH) ? LOAD_W : P_LEN_WIDTH;

   localparam logic [CNT_W-1:0]       CNT_ONE = 1;
   localparam logic [P_LEN_WIDTH-1:0] LEN_ONE = 1;
   localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;

   wvb_state_t             state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       load_val;
   logic [P_LEN_WIDTH-1:0] seg_cnt;
   logic [P_LEN_WIDTH-1:0] max_len_lat;
   logic                   mode_lat;
   logic [P_ADR_WIDTH-1:0] start_addr;
   logic [P_LTC_WIDTH-1:0] ltc_lat;
   logic [P_SRC_WIDTH-1:0] src_lat;
   logic                   seg_first;

   logic [CNT_W-1:0]       load_calc;
   logic [CNT_W-1:0]       first_cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic                   seg_full;
   logic [P_LTC_WIDTH-1:0] hdr_ltc;

   // cnt holds the writes still owed, counting the one in flight this cycle
   always_comb begin
      load_calc = CNT_W'(pre_config) + CNT_W'(post_config) + CNT_ONE;
      first_cnt = load_calc;
      if (trig_mode) begin
         first_cnt = (fixed_len_config == '0) ? CNT_ONE : CNT_W'(fixed_len_config);
      end
      cnt_next = cnt - CNT_ONE;
      if (trig && !mode_lat) begin
         cnt_next = load_val;
      end
      seg_full = (max_len_lat != '0) && (seg_cnt == max_len_lat);
      hdr_ltc  = seg_first ? ltc : ltc_lat;
   end

   assign armed = (state == IDLE);

   // A split segment's timestamp is the ltc of its first write, captured one edge after the split
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         load_val     <= '0;
         seg_cnt      <= '0;
         max_len_lat  <= '0;
         mode_lat     <= 1'b0;
         start_addr   <= '0;
         ltc_lat      <= '0;
         src_lat      <= '0;
         seg_first    <= 1'b0;
         wvb_wr_addr  <= '0;
         wvb_wren     <= 1'b0;
         hdr_data     <= '0;
         hdr_wren     <= 1'b0;
         eoe          <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         wvb_wren <= 1'b0;
         hdr_wren <= 1'b0;
         eoe      <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  if (overflow_in) begin
                     overflow_out <= 1'b1;
                     state        <= OVFL;
                  end else begin
                     state       <= WRITE;
                     wvb_wren    <= 1'b1;
                     cnt         <= first_cnt;
                     load_val    <= load_calc;
                     mode_lat    <= trig_mode;
                     max_len_lat <= max_len_config;
                     seg_cnt     <= LEN_ONE;
                     start_addr  <= wvb_wr_addr;
                     ltc_lat     <= ltc;
                     src_lat     <= trig_src;
                     seg_first   <= 1'b0;
                  end
               end
            end
            WRITE: begin
               wvb_wr_addr <= wvb_wr_addr + ADR_ONE;
               seg_first   <= 1'b0;
               if (seg_first) begin
                  ltc_lat <= ltc;
               end
               if (overflow_in) begin
                  hdr_wren     <= 1'b1;
                  eoe          <= 1'b1;
                  hdr_data     <= {1'b1, 1'b0, src_lat, hdr_ltc, wvb_wr_addr, start_addr};
                  overflow_out <= 1'b1;
                  cnt          <= '0;
                  seg_cnt      <= '0;
                  state        <= OVFL;
               end else if (cnt_next == '0) begin
                  hdr_wren <= 1'b1;
                  eoe      <= 1'b1;
                  hdr_data <= {1'b0, 1'b0, src_lat, hdr_ltc, wvb_wr_addr, start_addr};
                  cnt      <= '0;
                  seg_cnt  <= '0;
                  state    <= IDLE;
               end else if (seg_full) begin
                  hdr_wren   <= 1'b1;
                  hdr_data   <= {1'b0, 1'b1, src_lat, hdr_ltc, wvb_wr_addr, start_addr};
                  wvb_wren   <= 1'b1;
                  cnt        <= cnt_next;
                  seg_cnt    <= LEN_ONE;
                  start_addr <= wvb_wr_addr + ADR_ONE;
                  seg_first  <= 1'b1;
               end else begin
                  wvb_wren <= 1'b1;
                  cnt      <= cnt_next;
                  seg_cnt  <= seg_cnt + LEN_ONE;
               end
            end
            OVFL: begin
               if (arm && !overflow_in) begin
                  overflow_out <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wvb_seg_wr_ctrl.sv
// Directed self-checking bench for wvb_seg_wr_ctrl using a cycle-numbered write/header log.
module tb_wvb_seg_wr_ctrl;

   localparam int HDR_W = 76;

   logic              clk = 1'b0;
   logic              rst;
   logic [47:0]       ltc;
   logic [4:0]        pre_config;
   logic [7:0]        post_config;
   logic [11:0]       max_len_config;
   logic [11:0]       fixed_len_config;
   logic              trig_mode;
   logic              trig;
   logic [1:0]        trig_src;
   logic              arm;
   logic              overflow_in;
   logic              armed;
   logic [11:0]       wvb_wr_addr;
   logic              wvb_wren;
   logic [HDR_W-1:0]  hdr_data;
   logic              hdr_wren;
   logic              eoe;
   logic              overflow_out;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int next_addr = 0;

   int wr_cnt, wr_first_cyc, wr_last_cyc, wr_first_addr, wr_last_addr, eoe_cnt;
   logic [HDR_W-1:0] hdr_q[$];
   int hdr_cyc_q[$];
   bit hdr_eoe_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign ltc = 48'(cyc);

   wvb_seg_wr_ctrl #(
      .P_ADR_WIDTH(12), .P_LTC_WIDTH(48), .P_PRE_WIDTH(5),
      .P_POST_WIDTH(8), .P_LEN_WIDTH(12), .P_SRC_WIDTH(2)
   ) dut (
      .clk(clk), .rst(rst), .ltc(ltc), .pre_config(pre_config), .post_config(post_config),
      .max_len_config(max_len_config), .fixed_len_config(fixed_len_config),
      .trig_mode(trig_mode), .trig(trig), .trig_src(trig_src), .arm(arm),
      .overflow_in(overflow_in), .armed(armed), .wvb_wr_addr(wvb_wr_addr),
      .wvb_wren(wvb_wren), .hdr_data(hdr_data), .hdr_wren(hdr_wren), .eoe(eoe),
      .overflow_out(overflow_out)
   );

   // Log every write and header with the cycle number it appeared in
   always @(negedge clk) begin
      if (rst) begin
         if (wvb_wren) begin
            if (wr_cnt == 0) begin
               wr_first_cyc  = cyc;
               wr_first_addr = int'(wvb_wr_addr);
            end
            wr_last_cyc  = cyc;
            wr_last_addr = int'(wvb_wr_addr);
            wr_cnt++;
         end
         if (hdr_wren) begin
            hdr_q.push_back(hdr_data);
            hdr_cyc_q.push_back(cyc);
            hdr_eoe_q.push_back(eoe);
         end
         if (eoe) eoe_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
      checks++;
      if (obs !== exp_val) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp_val);
      end
   endtask

   task automatic stepTo(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse trig for exactly cycle t
   task automatic applyStimulus(input int t);
      stepTo(t);
      trig = 1'b1;
      stepTo(t + 1);
      trig = 1'b0;
   endtask

   task automatic clearLog();
      wr_cnt = 0; wr_first_cyc = -1; wr_last_cyc = -1;
      wr_first_addr = -1; wr_last_addr = -1; eoe_cnt = 0;
      hdr_q.delete(); hdr_cyc_q.delete(); hdr_eoe_q.delete();
   endtask

   task automatic checkWrites(input string tag, input int n, input int first_c, input int last_c, input int first_a);
      checkOutput({tag, "_wr_cnt"}, wr_cnt, n);
      checkOutput({tag, "_wr_first_cyc"}, wr_first_cyc, first_c);
      checkOutput({tag, "_wr_last_cyc"}, wr_last_cyc, last_c);
      checkOutput({tag, "_wr_first_addr"}, wr_first_addr, first_a);
      checkOutput({tag, "_wr_last_addr"}, wr_last_addr, (first_a + n - 1) % 4096);
   endtask

   task automatic checkHdr(input string tag, input int idx, input int e_cyc, input int e_start,
                           input int e_stop, input int e_ltc, input int e_src, input int e_cont,
                           input int e_ovfl, input int e_eoe);
      logic [HDR_W-1:0] h;
      if (idx >= hdr_q.size()) begin
         checkOutput({tag, "_present"}, 0, 1);
      end else begin
         h = hdr_q[idx];
         checkOutput({tag, "_cyc"}, hdr_cyc_q[idx], e_cyc);
         checkOutput({tag, "_start"}, h[11:0], e_start % 4096);
         checkOutput({tag, "_stop"}, h[23:12], e_stop % 4096);
         checkOutput({tag, "_ltc"}, h[71:24], e_ltc);
         checkOutput({tag, "_src"}, h[73:72], e_src);
         checkOutput({tag, "_cont"}, h[74], e_cont);
         checkOutput({tag, "_ovfl"}, h[75], e_ovfl);
         checkOutput({tag, "_eoe"}, hdr_eoe_q[idx], e_eoe);
      end
   endtask

   initial begin
      int b, s, n;
      rst = 1'b0; trig = 1'b0; trig_src = 2'd0; arm = 1'b0; overflow_in = 1'b0;
      pre_config = 5'd4; post_config = 8'd4; max_len_config = 12'd0;
      fixed_len_config = 12'd0; trig_mode = 1'b0;
      clearLog();
      @(posedge clk); #1;
      stepTo(4);
      checkOutput("rst_armed", armed, 1);
      checkOutput("rst_addr", wvb_wr_addr, 0);
      checkOutput("rst_wren", wvb_wren, 0);
      checkOutput("rst_hdr_wren", hdr_wren, 0);
      checkOutput("rst_eoe", eoe, 0);
      checkOutput("rst_ovf", overflow_out, 0);
      checkOutput("rst_hdr_zero", (hdr_data == '0), 1);
      rst = 1'b1;
      stepTo(6);

      // Single waveform; config changed after acceptance must not matter
      clearLog(); b = cyc + 2; trig_src = 2'd2;
      applyStimulus(b);
      pre_config = 5'd0; post_config = 8'd0;
      stepTo(b + 3);
      checkOutput("t1_armed_busy", armed, 0);
      stepTo(b + 14);
      pre_config = 5'd4; post_config = 8'd4;
      checkWrites("t1", 9, b + 1, b + 9, next_addr);
      checkOutput("t1_hdr_cnt", hdr_q.size(), 1);
      checkHdr("t1_h0", 0, b + 10, next_addr, next_addr + 8, b, 2, 0, 0, 1);
      checkOutput("t1_armed_after", armed, 1);
      next_addr += 9;

      // Retrigger extends
      clearLog(); b = cyc + 2; trig_src = 2'd1;
      applyStimulus(b); applyStimulus(b + 4);
      stepTo(b + 18);
      checkWrites("t2", 13, b + 1, b + 13, next_addr);
      checkOutput("t2_hdr_cnt", hdr_q.size(), 1);
      checkHdr("t2_h0", 0, b + 14, next_addr, next_addr + 12, b, 1, 0, 0, 1);
      next_addr += 13;

      // Retrigger with segment cap 8 splits into two headers
      clearLog(); b = cyc + 2; trig_src = 2'd3; max_len_config = 12'd8;
      applyStimulus(b); applyStimulus(b + 4);
      stepTo(b + 18);
      checkWrites("t3", 13, b + 1, b + 13, next_addr);
      checkOutput("t3_hdr_cnt", hdr_q.size(), 2);
      checkOutput("t3_eoe_cnt", eoe_cnt, 1);
      checkHdr("t3_h0", 0, b + 9, next_addr, next_addr + 7, b, 3, 1, 0, 0);
      checkHdr("t3_h1", 1, b + 14, next_addr + 8, next_addr + 12, b + 9, 3, 0, 0, 1);
      next_addr += 13;

      // Cap equal to waveform length: no split
      clearLog(); b = cyc + 2; max_len_config = 12'd9; trig_src = 2'd0;
      applyStimulus(b);
      stepTo(b + 14);
      checkOutput("t3b_hdr_cnt", hdr_q.size(), 1);
      checkHdr("t3b_h0", 0, b + 10, next_addr, next_addr + 8, b, 0, 0, 0, 1);
      next_addr += 9;
      max_len_config = 12'd0;

      // Fixed mode, retrigger ignored
      clearLog(); b = cyc + 2; trig_mode = 1'b1; fixed_len_config = 12'd6;
      applyStimulus(b); applyStimulus(b + 2);
      stepTo(b + 12);
      checkWrites("t4", 6, b + 1, b + 6, next_addr);
      checkOutput("t4_hdr_cnt", hdr_q.size(), 1);
      checkHdr("t4_h0", 0, b + 7, next_addr, next_addr + 5, b, 0, 0, 0, 1);
      next_addr += 6;

      // Fixed length 0 behaves as 1
      clearLog(); b = cyc + 2; fixed_len_config = 12'd0;
      applyStimulus(b);
      stepTo(b + 6);
      checkWrites("t5", 1, b + 1, b + 1, next_addr);
      checkHdr("t5_h0", 0, b + 2, next_addr, next_addr, b, 0, 0, 0, 1);
      next_addr += 1;
      trig_mode = 1'b0;

      // Maximum pre+post must not truncate: 31+255+1 samples
      clearLog(); b = cyc + 2; pre_config = 5'd31; post_config = 8'd255;
      applyStimulus(b);
      stepTo(b + 292);
      checkWrites("t6", 287, b + 1, b + 287, next_addr);
      checkOutput("t6_hdr_cnt", hdr_q.size(), 1);
      next_addr += 287;
      pre_config = 5'd4; post_config = 8'd4;

      // Overflow during WRITE
      clearLog(); b = cyc + 2;
      applyStimulus(b);
      stepTo(b + 3); overflow_in = 1'b1;
      stepTo(b + 5);
      checkOutput("t7_ovf", overflow_out, 1);
      checkOutput("t7_armed", armed, 0);
      overflow_in = 1'b0;
      applyStimulus(b + 6);
      stepTo(b + 8); arm = 1'b1;
      checkOutput("t7_armed_pre_arm", armed, 0);
      stepTo(b + 9); arm = 1'b0;
      checkOutput("t7_armed_post_arm", armed, 1);
      checkOutput("t7_ovf_clr", overflow_out, 0);
      checkWrites("t7", 3, b + 1, b + 3, next_addr);
      checkOutput("t7_hdr_cnt", hdr_q.size(), 1);
      checkHdr("t7_h0", 0, b + 4, next_addr, next_addr + 2, b, 0, 0, 1, 1);
      next_addr += 3;

      // Overflow at trigger: nothing written, lockout until arm
      clearLog(); b = cyc + 2; overflow_in = 1'b1;
      applyStimulus(b);
      stepTo(b + 2);
      checkOutput("t8_ovf", overflow_out, 1);
      checkOutput("t8_armed", armed, 0);
      applyStimulus(b + 3);
      stepTo(b + 4); overflow_in = 1'b0;
      stepTo(b + 5); arm = 1'b1;
      checkOutput("t8_armed_pre_arm", armed, 0);
      stepTo(b + 6); arm = 1'b0;
      checkOutput("t8_armed_post_arm", armed, 1);
      checkOutput("t8_ovf_clr", overflow_out, 0);
      checkOutput("t8_wr_cnt", wr_cnt, 0);
      checkOutput("t8_hdr_cnt", hdr_q.size(), 0);

      // Advance the address to 4090 with one long fixed-length waveform
      clearLog(); b = cyc + 2; trig_mode = 1'b1; n = 4090 - next_addr;
      fixed_len_config = 12'(n);
      applyStimulus(b);
      stepTo(b + n + 4);
      checkOutput("fill_wr_cnt", wr_cnt, n);
      checkHdr("fill_h0", 0, b + n + 1, next_addr, 4089, b, 0, 0, 0, 1);
      next_addr = 4090; trig_mode = 1'b0;

      // Address wrap, then back-to-back trigger in the header cycle
      clearLog(); b = cyc + 2; s = next_addr;
      applyStimulus(b); applyStimulus(b + 10);
      stepTo(b + 24);
      checkWrites("t9", 18, b + 1, b + 19, s);
      checkOutput("t9_hdr_cnt", hdr_q.size(), 2);
      checkHdr("t9_h0", 0, b + 10, 4090, 2, b, 0, 0, 0, 1);
      checkHdr("t9_h1", 1, b + 20, 3, 11, b + 10, 0, 0, 0, 1);

      // Reset mid-waveform aborts without a header
      clearLog(); b = cyc + 2;
      applyStimulus(b);
      stepTo(b + 3); rst = 1'b0;
      stepTo(b + 5); rst = 1'b1;
      stepTo(b + 6);
      checkOutput("t10_addr", wvb_wr_addr, 0);
      checkOutput("t10_armed", armed, 1);
      checkOutput("t10_wren", wvb_wren, 0);
      stepTo(b + 16);
      checkOutput("t10_hdr_cnt", hdr_q.size(), 0);
      checkOutput("t10_eoe_cnt", eoe_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
